// File: rtl/tick_tx.sv
// Burst pulse transmitter: sends burst_len fixed-width ticks on tick_out.
// A hex display shows the cumulative count of ticks sent.
module tick_tx #(
  parameter int unsigned TICK_HIGH_CYC = 5_000_000,
  parameter int unsigned TICK_LOW_CYC  = 45_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] burst_len,
  output logic       tick_out,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  // state | meaning
  // IDLE  | waiting for a start edge
  // HIGH  | tick_out high, counting TICK_HIGH_CYC
  // LOW   | tick_out low, counting TICK_LOW_CYC
  // DONE  | one-cycle done pulse, then IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned MAX_CYC = (TICK_HIGH_CYC > TICK_LOW_CYC) ? TICK_HIGH_CYC : TICK_LOW_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(TICK_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(TICK_LOW_CYC - 1);

  logic             start_meta_q, start_sync_q, start_prev_q;
  logic             stop_meta_q, stop_sync_q;
  logic             start_edge;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rem_q, rem_d, rem_dec;
  logic [3:0]       sent_q, sent_d;
  logic             tick_q, busy_q, done_q;

  assign start_edge = start_sync_q & ~start_prev_q;
  assign rem_dec    = rem_q - 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge && !stop_sync_q) begin
          state_d = S_HIGH;
          cnt_d   = HIGH_LD;
          rem_d   = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
          sent_d  = sent_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (stop_sync_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = LOW_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (stop_sync_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          rem_d = rem_dec;
          if (rem_dec != 5'd0) begin
            state_d = S_HIGH;
            cnt_d   = HIGH_LD;
            sent_d  = sent_q + 4'd1;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      stop_meta_q  <= 1'b0;
      stop_sync_q  <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= 5'd0;
      sent_q       <= 4'd0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      stop_meta_q  <= stop;
      stop_sync_q  <= stop_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      sent_q       <= sent_d;
      // Outputs registered from next state so they align with state_q.
      tick_q       <= (state_d == S_HIGH);
      busy_q       <= (state_d == S_HIGH) || (state_d == S_LOW);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign tick_out = tick_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign an       = 4'b1110;

  always_comb begin
    seg = 7'b1111111;
    case (sent_q)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_tick_tx.sv
// Bench for tick_tx with short phases: per-cycle reference model, burst
// vector table and hand-written corner sequences.
module tb_tick_tx;
  localparam int H = 3;
  localparam int L = 5;
  localparam int P = H + L;

  logic       clk_100MHz = 1'b0;
  logic       reset, start, stop;
  logic [3:0] burst_len;
  logic       tick_out, busy, done;
  logic [6:0] seg;
  logic [3:0] an;

  tick_tx #(.TICK_HIGH_CYC(H), .TICK_LOW_CYC(L)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .stop(stop),
    .burst_len(burst_len), .tick_out(tick_out), .busy(busy), .done(done),
    .seg(seg), .an(an)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [3:0] bl;
    int         stop_at;
    int         run;
    int         exp_pulses;
    int         exp_dones;
    logic [3:0] exp_sent;
  } vec_t;

  logic [6:0] seg_tab [16];
  vec_t       vecs [7];
  int         checks = 0;
  int         failures = 0;

  // Reference model: a burst is a position counter over n periods of P cycles.
  bit         m_act;
  int         m_pos, m_n;
  logic [3:0] m_sent;
  bit         sh [3];
  bit         ph [3];
  int         pulses, dones;
  logic       prev_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit s_edge, s_stop;
    s_edge = sh[1] & ~sh[2];
    s_stop = ph[1];
    if (reset) begin
      m_act = 0; m_pos = 0; m_n = 0; m_sent = 4'd0;
      sh = '{0, 0, 0}; ph = '{0, 0, 0};
    end else begin
      if (m_act) begin
        if (m_pos == m_n * P) m_act = 0;
        else if (s_stop) m_act = 0;
        else begin
          m_pos++;
          if (m_pos < m_n * P && (m_pos % P) == 0) m_sent = m_sent + 4'd1;
        end
      end else if (s_edge && !s_stop) begin
        m_act = 1; m_pos = 0;
        m_n = (burst_len == 4'd0) ? 16 : int'(burst_len);
        m_sent = m_sent + 4'd1;
      end
      sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start;
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = stop;
    end
  endtask

  task automatic step();
    logic e_tick, e_busy, e_done;
    @(posedge clk_100MHz);
    model_edge();
    #1;
    e_busy = m_act && (m_pos < m_n * P);
    e_tick = e_busy && ((m_pos % P) < H);
    e_done = m_act && (m_pos == m_n * P);
    chk("tick_out", {31'd0, tick_out}, {31'd0, e_tick});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("seg", {25'd0, seg}, {25'd0, seg_tab[m_sent]});
    chk("an", {28'd0, an}, 32'hE);
    if (tick_out === 1'b1 && prev_tick === 1'b0) pulses++;
    if (done === 1'b1) dones++;
    prev_tick = tick_out;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    step();
    reset = 1'b0;
    pulses = 0; dones = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    do_reset();
    burst_len = v.bl;
    for (int k = 1; k <= v.run; k++) begin
      start = (k <= 2);
      stop  = (v.stop_at > 0 && k >= v.stop_at);
      step();
    end
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk($sformatf("vec%0d_pulses", idx), pulses, v.exp_pulses);
    chk($sformatf("vec%0d_dones", idx), dones, v.exp_dones);
    chk($sformatf("vec%0d_seg", idx), {25'd0, seg}, {25'd0, seg_tab[v.exp_sent]});
    chk($sformatf("vec%0d_idle", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    //        bl     stop_at run  pulses dones sent
    vecs[0] = '{4'd3,  -1,  40,  3, 1, 4'd3};
    vecs[1] = '{4'd0,  -1, 140, 16, 1, 4'd0};
    vecs[2] = '{4'd4,  10,  30,  2, 0, 4'd2};
    vecs[3] = '{4'd1,  -1,  20,  1, 1, 4'd1};
    vecs[4] = '{4'd15, -1, 130, 15, 1, 4'd15};
    vecs[5] = '{4'd5,   1,  20,  0, 0, 4'd0};
    vecs[6] = '{4'd3,   6,  20,  1, 0, 4'd1};

    m_act = 0; m_pos = 0; m_n = 0; m_sent = 4'd0;
    sh = '{0, 0, 0}; ph = '{0, 0, 0};
    prev_tick = 1'b0; pulses = 0; dones = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; burst_len = 4'd0;
    step(); step();
    chk("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    chk("rst_tick", {31'd0, tick_out}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // tick_out rises on the third edge after start is first sampled
    do_reset();
    burst_len = 4'd1;
    start = 1'b1;
    step(); chk("lat_e1", {31'd0, tick_out}, 32'd0);
    step(); chk("lat_e2", {31'd0, tick_out}, 32'd0);
    step(); chk("lat_e3", {31'd0, tick_out}, 32'd1);
    start = 1'b0;
    repeat (15) step();

    // restart mid-burst ignored, burst_len change mid-burst ignored
    do_reset();
    burst_len = 4'd2;
    for (int k = 1; k <= 30; k++) begin
      start = (k <= 2) || (k == 12) || (k == 13);
      if (k == 5) burst_len = 4'd7;
      step();
    end
    chk("rearm_pulses", pulses, 2);
    chk("rearm_dones", dones, 1);
    burst_len = 4'd2;
    for (int k = 1; k <= 30; k++) begin
      start = (k <= 2);
      step();
    end
    chk("rearm_total", pulses, 4);
    chk("rearm_seg", {25'd0, seg}, {25'd0, 7'b0011001});

    // start edge landing in DONE is dropped
    do_reset();
    burst_len = 4'd1;
    for (int k = 1; k <= 25; k++) begin
      start = (k <= 2) || (k >= 10 && k <= 13);
      step();
    end
    chk("done_ign_pulses", pulses, 1);

    // reset in the middle of a high phase
    do_reset();
    burst_len = 4'd3;
    for (int k = 1; k <= 4; k++) begin
      start = (k <= 2);
      step();
    end
    chk("midrst_pre_tick", {31'd0, tick_out}, 32'd1);
    reset = 1'b1;
    step();
    chk("midrst_tick", {31'd0, tick_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    chk("midrst_an", {28'd0, an}, 32'hE);
    reset = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) start = ~start;
      if (stop) begin
        if ($urandom_range(0, 4) == 0) stop = 1'b0;
      end else if ($urandom_range(0, 149) == 0) stop = 1'b1;
      if ($urandom_range(0, 29) == 0) burst_len = 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_tx.md
TICK_TX -- requirements
Module: tick_tx

Interface
REQ-001 SHALL have parameter TICK_HIGH_CYC, default 5_000_000, clk cycles tick_out is held high per tick (50 ms at 100 MHz); legal values are 1 or greater.
REQ-002 SHALL have parameter TICK_LOW_CYC, default 45_000_000, clk cycles tick_out is held low after each tick; legal values are 1 or greater.
REQ-003 SHALL have port clk_100MHz  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  asynchronous button, request one burst.
REQ-006 SHALL have port stop  input  1  asynchronous button, abort current burst.
REQ-007 SHALL have port burst_len  input  4  ticks per burst from switches; 0 means 16.
REQ-008 SHALL have port tick_out  output  1  pulse train to Arduino, PMOD JB pin 1, registered.
REQ-009 SHALL have port busy  output  1  high while a burst is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a burst completes normally.
REQ-011 SHALL have port seg  output  7  segments gfedcba, active-low.
REQ-012 SHALL have port an  output  4  anodes, active-low.

Function
REQ-013 SHALL pass start and stop through 2-FF synchronizers; start acts only on a rising edge of its synchronized value; stop is level-sensitive after synchronization.
REQ-014 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-015 IDLE: on start edge, SHALL latch burst_len (0 becomes 16) into a 5-bit remaining counter and go to HIGH; tick_out rises on the 3rd rising clk edge after start is first sampled high.
REQ-016 HIGH: tick_out SHALL be 1 for exactly TICK_HIGH_CYC cycles, then go to LOW.
REQ-017 LOW: tick_out SHALL be 0 for exactly TICK_LOW_CYC cycles, then remaining decrements; if the result is nonzero go to HIGH, else go to DONE.
REQ-018 DONE: done SHALL be 1 for exactly one cycle, then go to IDLE; tick_out is 0.
REQ-019 busy SHALL be 1 in HIGH and LOW, and 0 in IDLE and DONE.
REQ-020 A 4-bit sent_count SHALL increment on every IDLE->HIGH and LOW->HIGH transition, i.e. once per tick_out rising edge.
REQ-021 sent_count SHALL wrap 15->0, is cumulative across bursts, and is cleared only by reset, so it matches the receiving counter.
REQ-022 SHALL hold an at 4'b1110 and drive seg from sent_count as hex 0-F, segment order gfedcba, active-low (for example 0 = 1000000, 1 = 1111001, F = 0001110).
REQ-023 start edges while busy=1 or in DONE SHALL be ignored and not queued.
REQ-024 stop=1 (synchronized) in HIGH or LOW SHALL force tick_out to 0 on the next edge and return the FSM to IDLE, without a done pulse and without changing sent_count.
REQ-025 If stop and a start edge are present in the same cycle in IDLE, stop SHALL win and no burst starts.
REQ-026 Changes to burst_len during a burst SHALL have no effect until the next start.
REQ-027 The phase cycle counter SHALL be sized for max(TICK_HIGH_CYC, TICK_LOW_CYC) and reloaded on every state entry.

Reset
REQ-028 reset=1 at a rising edge SHALL, at any point including mid-tick, set FSM=IDLE, tick_out=0, busy=0, done=0, sent_count=0, remaining=0, the phase counter to 0 and the synchronizer flops to 0.
REQ-029 Following REQ-028, seg SHALL show 1000000 and an SHALL be 1110.
REQ-030 reset SHALL take priority over start and stop.

Verification (TICK_HIGH_CYC=3, TICK_LOW_CYC=5)
REQ-031 burst_len=3, pulse start -> 3 tick_out pulses each 3 high and 5 low, done on the cycle after the 3rd low phase, seg ends 0110000 (3).
REQ-032 burst_len=0, start -> 16 pulses, sent_count wraps to 0, seg 1000000, one done pulse.
REQ-033 burst_len=4, start, assert stop during the 2nd high phase -> tick_out 0 next cycle, busy 0, no done, sent_count=2.
REQ-034 burst_len=2, second start edge mid-burst -> still exactly 2 pulses, then a fresh start yields 2 more, sent_count=4.
REQ-035 reset asserted during a high phase -> tick_out, busy and sent_count are 0 the next cycle, an=1110, seg=1000000.
REQ-036 stop held together with a start edge in IDLE -> tick_out stays 0 and busy stays 0.
